uart_tx_buffered: RTL and testbench

- Single-clock UART transmit path with an internal byte FIFO.
- Upstream logic pushes bytes with a valid/ready handshake; the block serialises each byte as one frame: start, 8 data bits LSB first, parity, stop.
- Bit timing comes from an internal clock-enable divider, so no separate serial clock is needed.
- Counterpart of the buffered receive path; the parity bit it sends is the one the receiver checks to flag a parity error.

---
 rtl/uart_tx_buffered.sv | 148 ++++++++++++++
 tb/tb_uart_tx_buffered.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding an 8E1/8O1 frame serialiser
// (start, 8 data bits LSB first, parity, stop) timed by an internal divider.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                  pclk_i,
    input  logic                  prst_n_i,
    input  logic [7:0]            tx_pdata_i,
    input  logic                  tx_pdata_valid_i,
    output logic                  tx_pready_o,
    output logic                  tx_sdata_o,
    output logic                  tx_busy_o,
    output logic [ADDR_WIDTH:0]   tx_fifo_count_o
);
    localparam int               DIV_W    = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t              state_reg, state_next;
    logic [DIV_W-1:0]    div_reg, div_next;
    logic [2:0]          bit_idx_reg, bit_idx_next;
    logic [7:0]          shift_reg, shift_next;
    logic                parity_reg, parity_next;
    logic [ADDR_WIDTH:0] wr_ptr_reg, rd_ptr_reg;
    logic [ADDR_WIDTH:0] fifo_count;
    logic [7:0]          rd_data_reg;
    logic [7:0]          mem [FIFO_DEPTH];
    logic                push, pop, fifo_empty, bit_done;

    assign fifo_count      = wr_ptr_reg - rd_ptr_reg;
    assign fifo_empty      = (fifo_count == '0);
    assign tx_pready_o     = (fifo_count < (ADDR_WIDTH + 1)'(FIFO_DEPTH));
    assign tx_fifo_count_o = fifo_count;
    assign push            = tx_pdata_valid_i && tx_pready_o;
    assign bit_done        = (div_reg == DIV_LAST);
    assign tx_busy_o       = (state_reg != ST_IDLE);

    // Storage array with a registered read port. The popped byte is only
    // needed once START ends, so the one-cycle read latency is hidden.
    always_ff @(posedge pclk_i) begin
        if (push) begin
            mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= tx_pdata_i;
        end
        if (pop) begin
            rd_data_reg <= mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            state_reg   <= ST_IDLE;
            div_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            div_reg     <= div_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            parity_reg  <= parity_next;
            wr_ptr_reg  <= wr_ptr_reg + {{ADDR_WIDTH{1'b0}}, push};
            rd_ptr_reg  <= rd_ptr_reg + {{ADDR_WIDTH{1'b0}}, pop};
        end
    end

    always_comb begin
        state_next   = state_reg;
        div_next     = div_reg + 1'b1;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        parity_next  = parity_reg;
        pop          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                div_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    div_next     = '0;
                    bit_idx_next = '0;
                    shift_next   = rd_data_reg;
                    parity_next  = (^rd_data_reg) ^ PARITY_ODD;
                    state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    div_next     = '0;
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    div_next   = '0;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Chain straight into the next start bit when more data waits.
                if (bit_done) begin
                    div_next = '0;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                div_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        tx_sdata_o = 1'b1;
        case (state_reg)
            ST_START:  tx_sdata_o = 1'b0;
            ST_DATA:   tx_sdata_o = shift_reg[0];
            ST_PARITY: tx_sdata_o = parity_reg;
            default:   tx_sdata_o = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: frame tables, corner sequences and
// random streams decoded by a line monitor against a queue-based model.
module tb_uart_tx_buffered;
    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int FRAME = 11 * CPB;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din_e, din_o;
    logic        vld_e, vld_o;
    logic        rdy_e, rdy_o, sd_e, sd_o, busy_e, busy_o;
    logic [AW:0] cnt_e, cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW), .PARITY_ODD(1'b0)) dut (
        .pclk_i(clk), .prst_n_i(rst_n), .tx_pdata_i(din_e), .tx_pdata_valid_i(vld_e),
        .tx_pready_o(rdy_e), .tx_sdata_o(sd_e), .tx_busy_o(busy_e), .tx_fifo_count_o(cnt_e)
    );

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW), .PARITY_ODD(1'b1)) dut_odd (
        .pclk_i(clk), .prst_n_i(rst_n), .tx_pdata_i(din_o), .tx_pdata_valid_i(vld_o),
        .tx_pready_o(rdy_o), .tx_sdata_o(sd_o), .tx_busy_o(busy_o), .tx_fifo_count_o(cnt_o)
    );

    typedef struct {
        logic [7:0]  data;
        logic        odd;
        logic [10:0] frame;   // bit i is the i-th bit on the line (bit 0 = start)
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       start;
        logic       par;
        logic       stop;
    } rx_t;

    rx_t        rx_q[$];
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: parity from a ones count, line level from bit position.
    function automatic logic model_parity(input logic [7:0] b, input logic odd);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return ((ones % 2) == 1) ^ odd;
    endfunction

    function automatic logic model_line(input logic [7:0] b, input logic odd, input int cyc);
        int bitno = cyc / CPB;
        if (bitno == 0) return 1'b0;
        if (bitno <= 8) return b[bitno-1];
        if (bitno == 9) return model_parity(b, odd);
        return 1'b1;
    endfunction

    // Line monitor on the even-parity instance: samples each bit mid-period.
    initial begin : monitor
        rx_t r;
        forever begin
            @(negedge clk);
            if (rst_n && sd_e == 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                r.start = sd_e;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    r.data[i] = sd_e;
                end
                repeat (CPB) @(negedge clk);
                r.par = sd_e;
                repeat (CPB) @(negedge clk);
                r.stop = sd_e;
                rx_q.push_back(r);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        din_e = b;
        vld_e = 1'b1;
        while (!rdy_e && waited < 2000) begin
            tick();
            waited++;
        end
        if (waited >= 2000) check("send_timeout", 32'd1, 32'd0);
        tick();
        vld_e = 1'b0;
        exp_q.push_back(b);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_e || busy_o || cnt_e != 0 || cnt_o != 0) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_rx(input int count, input int budget);
        int n = 0;
        while (rx_q.size() < count && n < budget) begin
            tick();
            n++;
        end
        check("rx_frames", rx_q.size(), count);
    endtask

    task automatic compare_stream(input string tag);
        rx_t        r;
        logic [7:0] e;
        check({tag, "_len"}, rx_q.size(), exp_q.size());
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_data"}, r.data, e);
            check({tag, "_parity"}, r.par, model_parity(e, 1'b0));
            check({tag, "_framing"}, {r.start, r.stop}, 2'b01);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    vec_t       vecs[7];
    logic [7:0] fill_b[18];
    int         acc, cyc, stall;

    initial begin
        din_e = '0; din_o = '0; vld_e = 1'b0; vld_o = 1'b0;
        vecs[0] = '{8'hA5, 1'b0, 11'h54A};
        vecs[1] = '{8'h00, 1'b1, 11'h600};
        vecs[2] = '{8'h01, 1'b1, 11'h402};
        vecs[3] = '{8'hFF, 1'b0, 11'h5FE};
        vecs[4] = '{8'h80, 1'b0, 11'h700};
        vecs[5] = '{8'h37, 1'b1, 11'h46E};
        vecs[6] = '{8'h37, 1'b0, 11'h66E};

        // Reset state
        tick(); tick();
        check("rst_line", sd_e, 1'b1);
        check("rst_busy", busy_e, 1'b0);
        check("rst_ready", rdy_e, 1'b1);
        check("rst_count", cnt_e, 0);
        check("rst_line_odd", sd_o, 1'b1);
        rst_n = 1'b1;
        tick();

        // Single-frame table: exact line level every cycle, 44-cycle busy window
        for (int v = 0; v < 7; v++) begin
            wait_idle();
            if (vecs[v].odd) begin
                din_o = vecs[v].data; vld_o = 1'b1;
            end else begin
                din_e = vecs[v].data; vld_e = 1'b1;
            end
            tick();
            vld_e = 1'b0; vld_o = 1'b0;
            check("tbl_count_accept", vecs[v].odd ? cnt_o : cnt_e, 1);
            check("tbl_line_before_pop", vecs[v].odd ? sd_o : sd_e, 1'b1);
            tick();
            check("tbl_count_pop", vecs[v].odd ? cnt_o : cnt_e, 0);
            for (int c = 0; c < FRAME; c++) begin
                check($sformatf("tbl%0d_bit%0d", v, c / CPB), vecs[v].odd ? sd_o : sd_e, vecs[v].frame[c / CPB]);
                check($sformatf("tbl%0d_busy", v), vecs[v].odd ? busy_o : busy_e, 1'b1);
                tick();
            end
            check("tbl_line_end", vecs[v].odd ? sd_o : sd_e, 1'b1);
            check("tbl_busy_end", vecs[v].odd ? busy_o : busy_e, 1'b0);
        end

        // Back-to-back: two frames with no idle gap, 88 busy cycles
        wait_idle();
        tick();
        rx_q.delete(); exp_q.delete();
        send_byte(8'h55);
        send_byte(8'h0F);
        for (int c = 0; c < 2 * FRAME; c++) begin
            check("b2b_line", sd_e, model_line(c < FRAME ? 8'h55 : 8'h0F, 1'b0, c % FRAME));
            check("b2b_busy", busy_e, 1'b1);
            tick();
        end
        check("b2b_busy_end", busy_e, 1'b0);
        wait_rx(2, 200);
        compare_stream("b2b");

        // Fill and backpressure with valid held high for 18 bytes
        wait_idle();
        tick();
        rx_q.delete(); exp_q.delete();
        for (int i = 0; i < 18; i++) fill_b[i] = 8'($urandom);
        acc = 0; cyc = 0;
        din_e = fill_b[0]; vld_e = 1'b1;
        while (rdy_e && acc < 18 && cyc < 100) begin
            tick();
            cyc++;
            exp_q.push_back(fill_b[acc]);
            acc++;
            if (acc == 1) check("fill_line_at_accept", sd_e, 1'b1);
            if (acc == 2) check("fill_line_after_pop", sd_e, 1'b0);
            if (acc < 18) din_e = fill_b[acc];
        end
        check("fill_accepted", acc, 17);
        check("fill_count_full", cnt_e, 16);
        check("fill_ready_low", rdy_e, 1'b0);
        stall = 0;
        while (!rdy_e && stall < 200) begin
            tick();
            stall++;
        end
        check("fill_stall_cycles", stall, 29);
        check("fill_count_after_pop", cnt_e, 15);
        tick();
        exp_q.push_back(fill_b[17]);
        vld_e = 1'b0;
        check("fill_count_refill", cnt_e, 16);
        wait_rx(18, 18 * FRAME + 200);
        compare_stream("fill");

        // Wrap-around: 40 random bytes in bursts of 10
        wait_idle();
        tick();
        rx_q.delete(); exp_q.delete();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) send_byte(8'($urandom));
            repeat ($urandom_range(0, 400)) tick();
        end
        wait_rx(40, 40 * FRAME + 400);
        compare_stream("wrap");

        // Random-gap stream
        wait_idle();
        tick();
        rx_q.delete(); exp_q.delete();
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send_byte(8'($urandom));
        end
        wait_rx(24, 24 * FRAME + 400);
        compare_stream("rand");

        // Reset during data bit 3 with three bytes queued
        wait_idle();
        tick();
        rx_q.delete(); exp_q.delete();
        send_byte(8'hF0);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        repeat (15) tick();
        check("rst_mid_pre_line", sd_e, 1'b0);
        check("rst_mid_pre_count", cnt_e, 3);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_line", sd_e, 1'b1);
        check("rst_mid_busy", busy_e, 1'b0);
        check("rst_mid_count", cnt_e, 0);
        check("rst_mid_ready", rdy_e, 1'b1);
        tick(); tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick();
            check("post_rst_line", sd_e, 1'b1);
            check("post_rst_busy", busy_e, 1'b0);
            check("post_rst_count", cnt_e, 0);
        end
        rx_q.delete(); exp_q.delete();
        send_byte(8'h3C);
        wait_rx(1, FRAME + 100);
        compare_stream("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
